// File: rtl/pk_stream_decoder.sv
// pk_stream_decoder
//   Decodes a Kyber public key byte stream: ByteEncode12(t[0..KYBER_K-1])
//   followed by the 32-byte seed rho. Each byte triple b0,b1,b2 yields two
//   12-bit coefficients c0 = {b1[3:0],b0} and c1 = {b2,b1[7:4]}.
//
//   Optional feature: define KYBER_PK_RANGE_CHECK_EN to flag (sticky err)
//   any emitted coefficient >= 3329. Without it err is tied to 0.
//
// Ports
//   clk, rst_n            clock, asynchronous active-low reset
//   start                 one-cycle pulse, begins a key (ignored while busy)
//   in_data/valid/ready   input byte stream handshake
//   coef_data/poly/idx    decoded coefficient and its position
//   coef_valid/ready      output coefficient handshake
//   rho, rho_valid        seed and its completion flag
//   busy, done, err       status: not idle, end-of-key pulse, range error
module pk_stream_decoder #(
  parameter int KYBER_K = 3,
  parameter int KYBER_N = 256
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         start,
  input  logic [7:0]   in_data,
  input  logic         in_valid,
  output logic         in_ready,
  output logic [11:0]  coef_data,
  output logic [1:0]   coef_poly,
  output logic [7:0]   coef_idx,
  output logic         coef_valid,
  input  logic         coef_ready,
  output logic [255:0] rho,
  output logic         rho_valid,
  output logic         busy,
  output logic         done,
  output logic         err
);

  localparam int TRIPLES = KYBER_K * KYBER_N / 2;
  localparam int TW      = (TRIPLES > 1) ? $clog2(TRIPLES) : 1;
  localparam logic [TW-1:0] LAST_TRIPLE = TW'(TRIPLES - 1);
  localparam logic [7:0]    LAST_IDX    = 8'(KYBER_N - 1);
  localparam logic [1:0]    LAST_POLY   = 2'(KYBER_K - 1);

  typedef enum logic [2:0] {IDLE, T_B0, T_B1, T_B2, RHO} state_t;

  state_t         state;
  logic [7:0]     b0_q;
  logic [3:0]     b1_hi_q;
  logic [TW-1:0]  triple_q;
  logic [4:0]     rho_cnt;
  logic           accept;
  logic           out_xfer;
  logic           produce;
  logic           start_acc;
  logic [11:0]    new_coef;

  assign busy      = (state != IDLE);
  // Back-pressure: never accept a byte that could overwrite an unsent coefficient.
  assign in_ready  = busy && (!coef_valid || coef_ready);
  assign accept    = in_valid && in_ready;
  assign out_xfer  = coef_valid && coef_ready;
  assign produce   = accept && ((state == T_B1) || (state == T_B2));
  assign start_acc = start && (state == IDLE);

  always_comb begin
    new_coef = {in_data, b1_hi_q};
    if (state == T_B1) new_coef = {in_data[3:0], b0_q};
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state      <= IDLE;
      b0_q       <= '0;
      b1_hi_q    <= '0;
      triple_q   <= '0;
      rho_cnt    <= '0;
      coef_data  <= '0;
      coef_poly  <= '0;
      coef_idx   <= '0;
      coef_valid <= 1'b0;
      rho        <= '0;
      rho_valid  <= 1'b0;
      done       <= 1'b0;
    end else begin
      done <= 1'b0;

      // coef_idx/coef_poly name the coefficient currently presented, so they
      // advance on each output transfer rather than on production.
      if (out_xfer) begin
        if (coef_idx == LAST_IDX) begin
          coef_idx  <= '0;
          coef_poly <= (coef_poly == LAST_POLY) ? '0 : coef_poly + 2'd1;
        end else begin
          coef_idx <= coef_idx + 8'd1;
        end
      end

      if (produce) begin
        coef_data  <= new_coef;
        coef_valid <= 1'b1;
      end else if (out_xfer) begin
        coef_valid <= 1'b0;
      end

      case (state)
        IDLE: begin
          if (start_acc) begin
            state     <= T_B0;
            rho_valid <= 1'b0;
            coef_idx  <= '0;
            coef_poly <= '0;
            triple_q  <= '0;
            rho_cnt   <= '0;
          end
        end
        T_B0: begin
          if (accept) begin
            b0_q  <= in_data;
            state <= T_B1;
          end
        end
        T_B1: begin
          if (accept) begin
            b1_hi_q <= in_data[7:4];
            state   <= T_B2;
          end
        end
        T_B2: begin
          if (accept) begin
            triple_q <= triple_q + 1'b1;
            state    <= (triple_q == LAST_TRIPLE) ? RHO : T_B0;
          end
        end
        RHO: begin
          if (accept) begin
            rho[{rho_cnt, 3'b000} +: 8] <= in_data;
            rho_cnt <= rho_cnt + 5'd1;
            if (rho_cnt == 5'd31) begin
              state     <= IDLE;
              rho_valid <= 1'b1;
              done      <= 1'b1;
            end
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

`ifdef KYBER_PK_RANGE_CHECK_EN
  // Checked at production; the coefficient itself is passed through unchanged.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)                               err <= 1'b0;
    else if (start_acc)                       err <= 1'b0;
    else if (produce && new_coef >= 12'd3329) err <= 1'b1;
  end
`else
  assign err = 1'b0;
`endif

endmodule

// File: doc/pk_stream_decoder.md
PK_STREAM_DECODER -- requirements
Module: pk_stream_decoder

Interface
REQ-001 SHALL have parameter KYBER_K, default 3, meaning the number of t polynomials (legal values 2, 3, 4).
REQ-002 SHALL have parameter KYBER_N, default 256, meaning coefficients per polynomial.
REQ-003 SHALL have port clk, input, 1 bit: the single clock; all logic is on the rising edge.
REQ-004 SHALL have port rst_n, input, 1 bit: asynchronous, active-low reset.
REQ-005 SHALL have port start, input, 1 bit: one-cycle pulse that begins decoding a key.
REQ-006 SHALL have port in_data, input, 8 bits: public-key byte stream.
REQ-007 SHALL have port in_valid, input, 1 bit: in_data is valid.
REQ-008 SHALL have port in_ready, output, 1 bit: the block accepts in_data.
REQ-009 SHALL have port coef_data, output, 12 bits: decoded t coefficient.
REQ-010 SHALL have port coef_poly, output, 2 bits: polynomial index, 0..KYBER_K-1.
REQ-011 SHALL have port coef_idx, output, 8 bits: coefficient index, 0..KYBER_N-1.
REQ-012 SHALL have port coef_valid, output, 1 bit; and port coef_ready, input, 1 bit: output handshake.
REQ-013 SHALL have port rho, output, 256 bits: seed; and port rho_valid, output, 1 bit: rho is complete.
REQ-014 SHALL have port busy, output, 1 bit; port done, output, 1 bit (one-cycle pulse); and port err, output, 1 bit.

Function
REQ-015 SHALL accept input bytes in the order ByteEncode12(t[0..KYBER_K-1]) followed by 32 rho bytes, 384*KYBER_K+32 bytes in total.
REQ-016 SHALL transfer an input byte in a cycle where in_valid and in_ready are both 1.
REQ-017 SHALL transfer an output coefficient in a cycle where coef_valid and coef_ready are both 1.
REQ-018 SHALL use the FSM states IDLE, T_B0, T_B1, T_B2, RHO, with these transitions:
- IDLE->T_B0 on start.
- T_B0->T_B1->T_B2 on each accepted byte.
- T_B2->T_B0 on an accepted byte.
- T_B2->RHO on the byte that completes coefficient KYBER_N-1 of polynomial KYBER_K-1.
- RHO->IDLE on the 32nd accepted rho byte.
REQ-019 SHALL compute c0 = {b1[3:0], b0} and c1 = {b2, b1[7:4]} from each byte triple b0, b1, b2.
REQ-020 SHALL present c0 with coef_valid=1 in the cycle after b1 is accepted, and c1 in the cycle after b2 is accepted.
REQ-021 SHALL drive in_ready = (state != IDLE) and (!coef_valid or coef_ready).
- Consequence: in_ready is 0 in IDLE, and no coefficient is ever dropped or overwritten.
REQ-022 SHALL hold coef_data, coef_poly and coef_idx stable while coef_valid=1 and coef_ready=0.
REQ-023 SHALL deassert coef_valid after a transfer unless a new coefficient is produced in the same cycle.
REQ-024 SHALL advance coef_idx after each emitted coefficient, wrapping KYBER_N-1->0 and then incrementing coef_poly.
REQ-025 SHALL write rho byte j (0..31) to rho[8j+7:8j].
REQ-026 SHALL set rho_valid and pulse done in the cycle after the 32nd rho byte is accepted.
REQ-027 SHALL hold rho and rho_valid until the next accepted start.
REQ-028 SHALL ignore start while busy=1; busy is 1 in every state other than IDLE.
REQ-029 SHALL, on an accepted start, clear rho_valid, err, coef_idx and coef_poly.
REQ-030 SHALL ignore in_valid while in IDLE.

Reset
REQ-031 SHALL, when rst_n=0, immediately force:
- FSM to IDLE.
- in_ready, coef_valid, rho_valid, busy, done, err = 0.
- coef_data, coef_poly, coef_idx = 0; rho = 0.
REQ-032 SHALL abandon any partial key on reset mid-operation and require a new start afterwards.

Configuration
REQ-033 SHALL compile in range checking when macro KYBER_PK_RANGE_CHECK_EN is defined.
- err is set (sticky) when any emitted coefficient is >= 3329 and cleared only by start or reset.
- The offending coefficient is still emitted unchanged.
REQ-034 SHALL, without KYBER_PK_RANGE_CHECK_EN, tie err to 0 and contain no comparator logic.

Verification
REQ-035 SHALL cover: KYBER_K=3, start, then bytes 0x01,0x23,0x45 with coef_ready=1 -> coefficients 0x301 (poly 0, idx 0) then 0x452 (idx 1), each one cycle after its last byte.
REQ-036 SHALL cover: a full 1184-byte key with rho bytes 0x00..0x1F -> 768 coefficients; rho[7:0]=0x00 and rho[255:248]=0x1F; rho_valid=1; a single done pulse.
REQ-037 SHALL cover: coef_ready held 0 for 10 cycles mid-polynomial -> in_ready=0, coef_data stable, no coefficient lost; the sequence resumes at the correct idx.
REQ-038 SHALL cover: with KYBER_PK_RANGE_CHECK_EN defined, bytes 0xFF,0x0F,0x00 -> coefficient 0xFFF emitted and err=1 until the next start; without the macro, err=0.
REQ-039 SHALL cover: rst_n=0 after 500 bytes, then a new start and a full key -> outputs match a clean run from idx 0, poly 0.
REQ-040 SHALL cover: KYBER_K=2 full key (800 bytes) -> last coefficient carries poly 1, idx 255; a start pulse while busy has no effect.
